// File: rtl/memory_stage_controller.sv
// Memory stage of the CPU pipeline: runs data-memory reads/writes and stack
// push/pop over a req/ack port, resolves conditional jumps, and produces
// registered one-cycle writeback / SP-update / PC-load / bus-error strobes.
//
// Handshake: mem_req is high for every cycle spent in ACCESS, and mem_we,
// mem_addr and mem_wdata are held constant for that whole time. The access
// completes at the first posedge where mem_ack is sampled high (mem_rdata is
// taken on that same edge). stall mirrors mem_req, so the upstream register
// holds the current op until the access is finished or aborted.
module memory_stage_controller #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] result_in,
  input  logic [7:0]  addr_in,
  input  logic [3:0]  c_addr_in,
  input  logic        reg_write_in,
  input  logic        data_read_in,
  input  logic        data_write_in,
  input  logic        reg_addr_in,
  input  logic [1:0]  stack_ctl_in,
  input  logic [7:0]  stack_pointer_in,
  input  logic [1:0]  j_ctl_in,
  input  logic [1:0]  alu_flags_in,
  input  logic        stack_command_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall,
  output logic        wb_valid,
  output logic [15:0] wb_data,
  output logic [3:0]  wb_c_addr,
  output logic        sp_we,
  output logic [7:0]  sp_value,
  output logic        pc_load,
  output logic [7:0]  pc_target,
  output logic        bus_err,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;

  // Captured memory op (held for the whole access)
  logic        r_we, w_we_nxt;
  logic [7:0]  r_addr, w_addr_nxt;
  logic [15:0] r_wdata, w_wdata_nxt;
  logic        r_is_rd, w_is_rd_nxt;
  logic        r_is_push, w_is_push_nxt;
  logic        r_is_pop, w_is_pop_nxt;
  logic        r_reg_write, w_reg_write_nxt;
  logic [3:0]  r_c_addr, w_c_addr_nxt;
  logic [7:0]  r_sp, w_sp_nxt;
  logic        r_jump, w_jump_nxt;
  logic [7:0]  r_target, w_target_nxt;

  // Registered outputs
  logic        r_wb_valid, w_wb_valid_nxt;
  logic [15:0] r_wb_data, w_wb_data_nxt;
  logic [3:0]  r_wb_c_addr, w_wb_c_addr_nxt;
  logic        r_sp_we, w_sp_we_nxt;
  logic [7:0]  r_sp_value, w_sp_value_nxt;
  logic        r_pc_load, w_pc_load_nxt;
  logic [7:0]  r_pc_target, w_pc_target_nxt;
  logic        r_bus_err, w_bus_err_nxt;

  // Decode of the op currently presented by the upstream register
  logic        w_push, w_pop, w_wr, w_rd, w_mem_op, w_jump;
  logic [7:0]  w_eff_addr;

  // Op classification: stack beats data, write beats read
  always_comb begin
    w_push     = stack_command_in & (stack_ctl_in == 2'b01);
    w_pop      = stack_command_in & (stack_ctl_in == 2'b10);
    w_wr       = ~w_push & ~w_pop & data_write_in;
    w_rd       = ~w_push & ~w_pop & ~data_write_in & data_read_in;
    w_mem_op   = w_push | w_pop | w_wr | w_rd;
    w_eff_addr = reg_addr_in ? result_in[7:0] : addr_in;
    case (j_ctl_in)
      2'b01:   w_jump = 1'b1;
      2'b10:   w_jump = alu_flags_in[0];
      2'b11:   w_jump = alu_flags_in[1];
      default: w_jump = 1'b0;
    endcase
  end

  // Next-state, op capture and strobe generation
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_we_nxt        = r_we;
    w_addr_nxt      = r_addr;
    w_wdata_nxt     = r_wdata;
    w_is_rd_nxt     = r_is_rd;
    w_is_push_nxt   = r_is_push;
    w_is_pop_nxt    = r_is_pop;
    w_reg_write_nxt = r_reg_write;
    w_c_addr_nxt    = r_c_addr;
    w_sp_nxt        = r_sp;
    w_jump_nxt      = r_jump;
    w_target_nxt    = r_target;
    w_wb_valid_nxt  = 1'b0;
    w_wb_data_nxt   = r_wb_data;
    w_wb_c_addr_nxt = r_wb_c_addr;
    w_sp_we_nxt     = 1'b0;
    w_sp_value_nxt  = r_sp_value;
    w_pc_load_nxt   = 1'b0;
    w_pc_target_nxt = r_pc_target;
    w_bus_err_nxt   = 1'b0;

    case (r_state)
      S_ACCESS: begin
        if (mem_ack) begin
          w_state_nxt     = S_DONE;
          w_wb_valid_nxt  = r_reg_write | r_is_pop;
          w_wb_data_nxt   = (r_is_rd | r_is_pop) ? mem_rdata : r_wdata;
          w_wb_c_addr_nxt = r_c_addr;
          w_sp_we_nxt     = r_is_push | r_is_pop;
          w_sp_value_nxt  = r_is_push ? (r_sp - 8'd1) : (r_sp + 8'd1);
          w_pc_load_nxt   = r_jump;
          w_pc_target_nxt = r_target;
        end else if (r_cnt == CNT_W'(MAX_WAIT)) begin
          w_state_nxt   = S_DONE;
          w_bus_err_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        // IDLE and DONE decode the presented op identically
        w_state_nxt = S_IDLE;
        if (w_mem_op) begin
          w_state_nxt     = S_ACCESS;
          w_cnt_nxt       = '0;
          w_we_nxt        = w_push | w_wr;
          w_addr_nxt      = w_push ? stack_pointer_in :
                            w_pop  ? (stack_pointer_in + 8'd1) : w_eff_addr;
          w_wdata_nxt     = result_in;
          w_is_rd_nxt     = w_rd;
          w_is_push_nxt   = w_push;
          w_is_pop_nxt    = w_pop;
          w_reg_write_nxt = reg_write_in;
          w_c_addr_nxt    = c_addr_in;
          w_sp_nxt        = stack_pointer_in;
          w_jump_nxt      = w_jump;
          w_target_nxt    = addr_in;
        end else begin
          w_wb_valid_nxt  = reg_write_in;
          w_wb_data_nxt   = result_in;
          w_wb_c_addr_nxt = c_addr_in;
          w_pc_load_nxt   = w_jump;
          w_pc_target_nxt = addr_in;
        end
      end
    endcase
  end

  // State, capture and output registers; reset discards any in-flight op
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_is_rd     <= 1'b0;
      r_is_push   <= 1'b0;
      r_is_pop    <= 1'b0;
      r_reg_write <= 1'b0;
      r_c_addr    <= '0;
      r_sp        <= '0;
      r_jump      <= 1'b0;
      r_target    <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_data   <= '0;
      r_wb_c_addr <= '0;
      r_sp_we     <= 1'b0;
      r_sp_value  <= '0;
      r_pc_load   <= 1'b0;
      r_pc_target <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_wdata     <= w_wdata_nxt;
      r_is_rd     <= w_is_rd_nxt;
      r_is_push   <= w_is_push_nxt;
      r_is_pop    <= w_is_pop_nxt;
      r_reg_write <= w_reg_write_nxt;
      r_c_addr    <= w_c_addr_nxt;
      r_sp        <= w_sp_nxt;
      r_jump      <= w_jump_nxt;
      r_target    <= w_target_nxt;
      r_wb_valid  <= w_wb_valid_nxt;
      r_wb_data   <= w_wb_data_nxt;
      r_wb_c_addr <= w_wb_c_addr_nxt;
      r_sp_we     <= w_sp_we_nxt;
      r_sp_value  <= w_sp_value_nxt;
      r_pc_load   <= w_pc_load_nxt;
      r_pc_target <= w_pc_target_nxt;
      r_bus_err   <= w_bus_err_nxt;
    end
  end

  assign mem_req     = (r_state == S_ACCESS);
  assign stall       = (r_state == S_ACCESS);
  assign mem_we      = r_we;
  assign mem_addr    = r_addr;
  assign mem_wdata   = r_wdata;
  assign wb_valid    = r_wb_valid;
  assign wb_data     = r_wb_data;
  assign wb_c_addr   = r_wb_c_addr;
  assign sp_we       = r_sp_we;
  assign sp_value    = r_sp_value;
  assign pc_load     = r_pc_load;
  assign pc_target   = r_pc_target;
  assign bus_err     = r_bus_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_memory_stage_controller.sv
// Bench for memory_stage_controller: an upstream driver that advances on
// negedge unless stalled, a memory responder with programmable ack delay,
// and a scoreboard fed by a reference model of the memory stage.
module tb_memory_stage_controller;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 4;
  localparam int EW       = 40;
  localparam int RW       = 25;

  typedef struct packed {
    logic [15:0] result;
    logic [7:0]  addr;
    logic [3:0]  c_addr;
    logic        reg_write;
    logic        data_read;
    logic        data_write;
    logic        reg_addr;
    logic [1:0]  stack_ctl;
    logic [7:0]  sp;
    logic [1:0]  j_ctl;
    logic [1:0]  flags;
    logic        stack_cmd;
  } instr_t;

  logic        CLK, RST_N;
  logic [15:0] result_in;
  logic [7:0]  addr_in;
  logic [3:0]  c_addr_in;
  logic        reg_write_in, data_read_in, data_write_in, reg_addr_in;
  logic [1:0]  stack_ctl_in;
  logic [7:0]  stack_pointer_in;
  logic [1:0]  j_ctl_in, alu_flags_in;
  logic        stack_command_in;
  logic        mem_req, mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic        mem_ack, stall;
  logic        wb_valid;
  logic [15:0] wb_data;
  logic [3:0]  wb_c_addr;
  logic        sp_we;
  logic [7:0]  sp_value;
  logic        pc_load;
  logic [7:0]  pc_target;
  logic        bus_err;
  logic [1:0]  o_dbg_state;

  memory_stage_controller #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .result_in(result_in), .addr_in(addr_in), .c_addr_in(c_addr_in),
    .reg_write_in(reg_write_in), .data_read_in(data_read_in),
    .data_write_in(data_write_in), .reg_addr_in(reg_addr_in),
    .stack_ctl_in(stack_ctl_in), .stack_pointer_in(stack_pointer_in),
    .j_ctl_in(j_ctl_in), .alu_flags_in(alu_flags_in),
    .stack_command_in(stack_command_in),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_c_addr(wb_c_addr), .sp_we(sp_we), .sp_value(sp_value),
    .pc_load(pc_load), .pc_target(pc_target), .bus_err(bus_err),
    .o_dbg_state(o_dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];
  logic [RW-1:0] mreq_q[$];
  logic [15:0] rmem[256];
  logic [15:0] refmem[256];
  int ack_delay = 0;
  int acc_k = 0;

  // Clock and watchdog
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] pack_ev(input logic wv, input logic [15:0] wd,
      input logic [3:0] wc, input logic spw, input logic [7:0] spv,
      input logic pl, input logic [7:0] pt, input logic be);
    return {wv, wv ? wd : 16'h0, wv ? wc : 4'h0, spw, spw ? spv : 8'h0,
            pl, pl ? pt : 8'h0, be};
  endfunction

  function automatic logic [RW-1:0] pack_req(input logic we, input logic [7:0] a,
      input logic [15:0] wd);
    return {we, a, we ? wd : 16'h0};
  endfunction

  // Reference model: what one instruction must do, from the ISA rules
  task automatic model(input instr_t t, input int ad, output int exp_stall);
    logic push, pop, wr, rd, jmp;
    logic [7:0] a;
    logic [15:0] d;
    logic [EW-1:0] e;
    push = t.stack_cmd && (t.stack_ctl == 2'b01);
    pop  = t.stack_cmd && (t.stack_ctl == 2'b10);
    wr   = !push && !pop && t.data_write;
    rd   = !push && !pop && !t.data_write && t.data_read;
    jmp  = (t.j_ctl == 2'b01) || (t.j_ctl == 2'b10 && t.flags[0]) ||
           (t.j_ctl == 2'b11 && t.flags[1]);
    if (!(push || pop || wr || rd)) begin
      exp_stall = 0;
      e = pack_ev(t.reg_write, t.result, t.c_addr, 1'b0, 8'h0, jmp, t.addr, 1'b0);
    end else begin
      if (push)     a = t.sp;
      else if (pop) a = t.sp + 8'd1;
      else          a = t.reg_addr ? t.result[7:0] : t.addr;
      mreq_q.push_back(pack_req(push || wr, a, t.result));
      if (ad > MAX_WAIT) begin
        exp_stall = MAX_WAIT + 1;
        e = pack_ev(1'b0, 16'h0, 4'h0, 1'b0, 8'h0, 1'b0, 8'h0, 1'b1);
      end else begin
        exp_stall = ad + 1;
        d = (rd || pop) ? refmem[a] : t.result;
        if (push || wr) refmem[a] = t.result;
        e = pack_ev(t.reg_write || pop, d, t.c_addr, push || pop,
                    push ? t.sp - 8'd1 : t.sp + 8'd1, jmp, t.addr, 1'b0);
      end
    end
    if (e != '0) exp_q.push_back(e);
  endtask

  task automatic apply(input instr_t t);
    result_in        = t.result;
    addr_in          = t.addr;
    c_addr_in        = t.c_addr;
    reg_write_in     = t.reg_write;
    data_read_in     = t.data_read;
    data_write_in    = t.data_write;
    reg_addr_in      = t.reg_addr;
    stack_ctl_in     = t.stack_ctl;
    stack_pointer_in = t.sp;
    j_ctl_in         = t.j_ctl;
    alu_flags_in     = t.flags;
    stack_command_in = t.stack_cmd;
  endtask

  // Driver: present an op at negedge, then hold it while stall is high
  task automatic issue(input string name, input instr_t t, input int ad);
    int exp_stall;
    int n;
    model(t, ad, exp_stall);
    ack_delay = ad;
    apply(t);
    n = 0;
    @(negedge CLK);
    while (stall && n < 100) begin
      n++;
      @(negedge CLK);
    end
    chk({name, "_stall_cycles"}, 64'(n), 64'(exp_stall));
  endtask

  // Memory responder: checks the request, acks after ack_delay cycles
  always @(negedge CLK) begin
    if (!RST_N || !mem_req) begin
      mem_ack = 1'b0;
      acc_k = 0;
    end else begin
      if (acc_k == 0) begin
        if (mreq_q.size() == 0) begin
          chk("mem_req_unexpected", {mem_we, mem_addr, mem_wdata}, 0);
        end else begin
          chk("mem_req", pack_req(mem_we, mem_addr, mem_wdata), mreq_q.pop_front());
        end
      end
      if (acc_k == ack_delay) begin
        mem_ack = 1'b1;
        mem_rdata = rmem[mem_addr];
        if (mem_we) rmem[mem_addr] = mem_wdata;
      end else begin
        mem_ack = 1'b0;
        mem_rdata = 16'($urandom);
      end
      acc_k++;
    end
  end

  // Monitor: every strobe cycle must match the next expected event
  always @(negedge CLK) begin
    if (RST_N && (wb_valid || sp_we || pc_load || bus_err)) begin
      if (exp_q.size() == 0) begin
        chk("event_unexpected",
            pack_ev(wb_valid, wb_data, wb_c_addr, sp_we, sp_value, pc_load, pc_target, bus_err), 0);
      end else begin
        chk("event",
            pack_ev(wb_valid, wb_data, wb_c_addr, sp_we, sp_value, pc_load, pc_target, bus_err),
            exp_q.pop_front());
      end
    end
  end

  // Stimulus
  initial begin
    instr_t t;
    int ad;
    RST_N = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    apply('0);
    for (int i = 0; i < 256; i++) begin
      rmem[i] = 16'($urandom);
      refmem[i] = rmem[i];
    end
    rmem[8'h40] = 16'hBEEF;
    refmem[8'h40] = 16'hBEEF;

    repeat (2) @(negedge CLK);
    #1;
    chk("reset_outputs", {mem_req, stall, wb_valid, sp_we, pc_load, bus_err, mem_we,
        mem_addr, mem_wdata, wb_data, wb_c_addr, sp_value, pc_target}, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);

    t = '0; t.reg_write = 1; t.result = 16'h1234; t.c_addr = 4'd3;
    issue("alu_wb", t, 0);

    t = '0; t.data_read = 1; t.addr = 8'h40; t.reg_write = 1; t.c_addr = 4'd7;
    issue("read_ack3", t, 2);

    t = '0; t.stack_cmd = 1; t.stack_ctl = 2'b01; t.sp = 8'h00; t.result = 16'h00AA;
    issue("push_wrap", t, 0);

    t = '0; t.stack_cmd = 1; t.stack_ctl = 2'b10; t.sp = 8'hFF; t.c_addr = 4'd5;
    issue("pop_wrap", t, 0);

    t = '0; t.data_write = 1; t.data_read = 1; t.reg_addr = 1; t.result = 16'h0077;
    t.addr = 8'h12;
    issue("write_beats_read", t, 1);

    t = '0; t.data_read = 1; t.reg_addr = 1; t.result = 16'h0077; t.reg_write = 1;
    issue("read_back_77", t, 0);

    t = '0; t.stack_cmd = 1; t.stack_ctl = 2'b01; t.sp = 8'h30; t.data_write = 1;
    t.data_read = 1; t.result = 16'h5A5A; t.addr = 8'h31;
    issue("stack_beats_data", t, 1);

    t = '0; t.j_ctl = 2'b10; t.flags = 2'b01; t.addr = 8'h9C;
    issue("jmp_zero_taken", t, 0);

    t = '0; t.j_ctl = 2'b10; t.flags = 2'b10; t.addr = 8'h9C; t.reg_write = 1;
    t.result = 16'h0F0F; t.c_addr = 4'd1;
    issue("jmp_zero_not_taken", t, 0);

    t = '0; t.data_read = 1; t.addr = 8'h40; t.j_ctl = 2'b01; t.reg_write = 1;
    t.addr = 8'h22;
    issue("read_with_jump", t, 3);

    t = '0; t.data_read = 1; t.addr = 8'h40; t.reg_write = 1; t.j_ctl = 2'b01;
    issue("timeout", t, 100);

    t = '0; t.data_read = 1; t.addr = 8'h41; t.reg_write = 1;
    issue("ack_last_cycle", t, MAX_WAIT);

    t = '0;
    issue("bubble", t, 0);

    for (int i = 0; i < 300; i++) begin
      t.result     = 16'($urandom);
      t.addr       = 8'($urandom);
      t.c_addr     = 4'($urandom);
      t.reg_write  = 1'($urandom);
      t.data_read  = ($urandom_range(0, 2) == 0);
      t.data_write = ($urandom_range(0, 3) == 0);
      t.reg_addr   = 1'($urandom);
      t.stack_ctl  = 2'($urandom);
      t.sp         = 8'($urandom);
      t.j_ctl      = 2'($urandom);
      t.flags      = 2'($urandom);
      t.stack_cmd  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) t = '0;
      case ($urandom_range(0, 19))
        0:       ad = MAX_WAIT + 5;
        1:       ad = MAX_WAIT;
        default: ad = $urandom_range(0, 3);
      endcase
      issue("rand", t, ad);
    end

    apply('0);
    repeat (3) @(negedge CLK);
    chk("drain_events", 64'(exp_q.size()), 0);
    chk("drain_requests", 64'(mreq_q.size()), 0);

    // Reset in the middle of an access
    t = '0; t.data_read = 1; t.addr = 8'h55; t.reg_write = 1;
    mreq_q.push_back(pack_req(1'b0, 8'h55, 16'h0));
    ack_delay = 1000;
    apply(t);
    @(negedge CLK);
    @(negedge CLK);
    chk("req_before_reset", {mem_req, stall}, 2'b11);
    #2;
    RST_N = 1'b0;
    #1;
    chk("reset_drops_req", {mem_req, stall}, 0);
    chk("reset_clears_strobes", {wb_valid, sp_we, pc_load, bus_err}, 0);
    apply('0);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("reset_no_leftover", 64'(exp_q.size() + mreq_q.size()), 0);
    chk("reset_idle_after", {mem_req, stall}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_stage_controller.md
Name: memory_stage_controller

Overview:
- Consumes the fields held in the execute/memory pipeline register and carries them out in the memory stage of the CPU.
- Performs data-memory reads and writes and stack push/pop through a req/ack memory port.
- Resolves conditional jumps from the ALU flags.
- Produces registered writeback and PC-update outputs, and stalls the upstream pipeline register while a memory access is outstanding.

Parameters:
- MAX_WAIT, 15, cycles in ACCESS without mem_ack before the access aborts (must be ≥1).
- CNT_W, 4, width of the wait counter (2^CNT_W > MAX_WAIT).

Ports:
- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  asynchronous active-low reset
- result_in  in  16  ALU result / store data
- addr_in  in  8  data address / jump target
- c_addr_in  in  4  destination register
- reg_write_in, data_read_in, data_write_in, reg_addr_in  in  1 each  control bits
- stack_ctl_in  in  2  00 none, 01 push, 10 pop, 11 none
- stack_pointer_in  in  8  current SP
- j_ctl_in  in  2  00 none, 01 always, 10 if alu_flags_in[0] (zero), 11 if alu_flags_in[1] (neg)
- alu_flags_in  in  2  {neg, zero}
- stack_command_in  in  1  qualifies stack_ctl_in
- mem_req  out  1  access request
- mem_we  out  1  1 = write
- mem_addr  out  8  access address
- mem_wdata  out  16  write data
- mem_rdata  in  16  read data, valid with mem_ack
- mem_ack  in  1  access complete, sampled on posedge
- stall  out  1  hold the upstream pipeline register
- wb_valid  out  1  writeback strobe (1 cycle)
- wb_data  out  16  writeback value
- wb_c_addr  out  4  writeback register
- sp_we  out  1  SP update strobe
- sp_value  out  8  new SP
- pc_load  out  1  jump taken strobe
- pc_target  out  8  jump target
- bus_err  out  1  timeout strobe

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE, wait counter=0.
  - All registered outputs 0; mem_req, stall 0 immediately.
  - A reset during ACCESS drops mem_req at once; the op is discarded and SP is not updated.
- States: IDLE, ACCESS, DONE. DONE decodes its inputs exactly like IDLE.
- Upstream register changes on negedge; this block samples inputs on posedge, when they are stable.
- Op classification at posedge in IDLE/DONE, in priority order:
  - push = stack_command_in & stack_ctl_in==01
  - pop = stack_command_in & stack_ctl_in==10
  - else write = data_write_in; else read = data_read_in
  - Stack beats data; write beats read.
- Effective data address = reg_addr_in ? result_in[7:0] : addr_in.
- Memory op: capture the op fields, counter=0, go to ACCESS.
  - push: we=1, addr=SP, wdata=result_in
  - pop: we=0, addr=SP+1 (mod 256)
  - write: we=1, addr=effective, wdata=result_in
  - read: we=0, addr=effective
- ACCESS:
  - mem_req=1; mem_we/addr/wdata held constant from the captured op.
  - stall=state==ACCESS (combinational from state only).
- mem_ack at posedge in ACCESS → DONE, with registered one-cycle strobes:
  - wb_valid = captured reg_write | pop.
  - wb_data = mem_rdata for read/pop, else captured result.
  - sp_we=1 for push/pop; sp_value = SP−1 (push) or SP+1 (pop), mod 256.
- No ack while counter==MAX_WAIT → DONE with bus_err=1; wb_valid, sp_we and pc_load are 0.
  - Otherwise the counter increments each cycle in ACCESS.
- Non-memory op at posedge in IDLE/DONE: no state change beyond DONE→IDLE; wb_valid=reg_write_in, wb_data=result_in, wb_c_addr=c_addr_in. Latency is 1 cycle.
- Jump:
  - pc_load = j_ctl condition true; pc_target=addr_in.
  - Strobed together with writeback, i.e. 1 cycle after sampling for non-memory ops, on entry to DONE for memory ops.
  - Suppressed on bus_err.
- Strobes (wb_valid, sp_we, pc_load, bus_err) are high for exactly one cycle.
- Bubble (all controls 0): all strobes 0.
- Minimum memory-op latency is 2 posedges: one to enter ACCESS, one to sample ack.

Test Plan:
- Reset, then reg_write_in=1, result_in=0x1234, c_addr_in=3 → next posedge: wb_valid=1, wb_data=0x1234, wb_c_addr=3, stall never high.
- data_read_in=1, reg_addr_in=0, addr_in=0x40, reg_write_in=1; ack on 3rd cycle with rdata=0xBEEF → mem_req/stall high for 3 cycles, mem_addr=0x40, mem_we=0; then wb_data=0xBEEF, wb_valid=1.
- Push with SP=0x00, result_in=0x00AA, immediate ack → mem_we=1, mem_addr=0x00, wdata=0x00AA; sp_we=1, sp_value=0xFF (wrap). Then pop with SP=0xFF, rdata=0x00AA → mem_addr=0x00, sp_value=0x00, wb_data=0x00AA.
- data_write_in and data_read_in both 1, reg_addr_in=1, result_in=0x0077 → write at address 0x77; stack op asserted alongside a data op → stack op wins.
- j_ctl_in=10: alu_flags_in=01 → pc_load=1, pc_target=addr_in; alu_flags_in=10 → pc_load=0.
- Read with no ack for MAX_WAIT+1 cycles → bus_err=1 pulse, wb_valid=0, return to IDLE. Separately, assert RST_N low mid-ACCESS → mem_req and stall drop immediately.
